rbr_add_subb_arb: RTL and testbench



---
 rtl/rbr_add_subb_arb.sv | 206 ++++++++++++++++++++
 tb/tb_rbr_add_subb_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbr_add_subb_arb.sv
// rbr_add_subb_arb: round-robin share of one RBR adder/subtractor.
// Optional build macro: RBR_ARB_FIXED_PRIO_EN (lowest index wins, no rr_ptr).
//
// Ports:
//   clk, srst_n        clock, synchronous active-low reset
//   req_valid/ready    per-requester handshake (ready is one-hot or zero)
//   req_subb_a/b       per-requester negate controls
//   req_a/req_b        packed operands, requester k at [k*2W +: 2W]
//   rsp_valid/ready    result handshake
//   rsp_id, rsp_s      owner index and RBR result (+/-a)+(+/-b)
//
// Digit code: 00=-1, 01/10=0, 11=+1.

module rbr_add_subb #(
  parameter int W = 64
) (
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic           subb_a,
  input  logic           subb_b,
  output logic [2*W-1:0] s
);
  localparam int SW = W + 3;
  localparam logic [SW-1:0] BIAS = {3'b000, {W{1'b1}}};

  logic [2*W-1:0] an;
  logic [2*W-1:0] bn;
  logic [SW-1:0]  a_hi;
  logic [SW-1:0]  a_lo;
  logic [SW-1:0]  b_hi;
  logic [SW-1:0]  b_lo;
  logic [SW-1:0]  sum;
  logic [W-1:0]   mag;
  logic           neg;

  // Negating a digit is inverting both of its bits.
  // The exact sum is recoded digit by digit, so every
  // result that fits in W digits comes back exactly,
  // including ones that use digit W-1.
  always_comb begin
    an   = subb_a ? ~a : a;
    bn   = subb_b ? ~b : b;
    a_hi = '0;
    a_lo = '0;
    b_hi = '0;
    b_lo = '0;
    for (int i = 0; i < W; i++) begin
      a_hi[i] = an[2*i+1];
      a_lo[i] = an[2*i];
      b_hi[i] = bn[2*i+1];
      b_lo[i] = bn[2*i];
    end
    sum = a_hi + a_lo + b_hi + b_lo - BIAS - BIAS;
    neg = sum[SW-1];
    mag = neg ? W'(~sum + SW'(1)) : W'(sum);
    s   = '0;
    for (int i = 0; i < W; i++) begin
      s[2*i +: 2] = mag[i] ? (neg ? 2'b00 : 2'b11) : 2'b01;
    end
  end
endmodule

module rbr_add_subb_arb #(
  parameter int W    = 64,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_subb_a,
  input  logic [NREQ-1:0]   req_subb_b,
  input  logic [NREQ*2*W-1:0] req_a,
  input  logic [NREQ*2*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_s
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           accept_en;
  logic           any_req;
  logic           take;
  logic [IDW-1:0] g;
  logic [2*W-1:0] op_a;
  logic [2*W-1:0] op_b;
  logic           op_sa;
  logic           op_sb;
  logic [IDW-1:0] op_id;
  logic [2*W-1:0] add_s;

`ifdef RBR_ARB_FIXED_PRIO_EN
  always_comb begin
    any_req = 1'b0;
    g       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        g       = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;
  logic [IDW:0]   k;

  // Search upward from rr_ptr, wrapping at NREQ-1.
  always_comb begin
    any_req = 1'b0;
    g       = '0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (k >= (IDW+1)'(NREQ)) begin
        k = k - (IDW+1)'(NREQ);
      end
      if (!any_req && req_valid[k[IDW-1:0]]) begin
        any_req = 1'b1;
        g       = k[IDW-1:0];
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    accept_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept_en = 1'b1;
        if (any_req) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          accept_en = 1'b1;
          state_d   = any_req ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign take = accept_en & any_req;

  always_comb begin
    req_ready = '0;
    if (take && srst_n) req_ready[g] = 1'b1;
  end

  rbr_add_subb #(.W(W)) u_add (
    .a      (op_a),
    .b      (op_b),
    .subb_a (op_sa),
    .subb_b (op_sb),
    .s      (add_s)
  );

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q   <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sa     <= 1'b0;
      op_sb     <= 1'b0;
      op_id     <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        op_a  <= req_a[g*2*W +: 2*W];
        op_b  <= req_b[g*2*W +: 2*W];
        op_sa <= req_subb_a[g];
        op_sb <= req_subb_b[g];
        op_id <= g;
      end
      if (state_q == EXEC) begin
        rsp_s     <= add_s;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifndef RBR_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rr_ptr <= '0;
    end else if (take) begin
      rr_ptr <= (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);
    end
  end
`endif
endmodule

// File: tb/tb_rbr_add_subb_arb.sv
// tb_rbr_add_subb_arb: bench for rbr_add_subb_arb, W=4, NREQ=4.
// Table vectors, directed corner sequences and a random scoreboard run.

module tb_rbr_add_subb_arb;
  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int NOPS = 10000;

  logic        clk = 1'b0;
  logic        srst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_subb_a;
  logic [3:0]  req_subb_b;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_s;

  always #5 clk = ~clk;

  rbr_add_subb_arb #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .srst_n     (srst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_subb_a (req_subb_a),
    .req_subb_b (req_subb_b),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s)
  );

  typedef struct {
    int id;
    int val;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    bit         sa;
    bit         sb;
    int         exp;
  } vec_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         rr_m = 0;
  int         n_acc = 0;
  int         n_rsp = 0;
  bit         hold_prev = 0;
  logic [7:0] prev_s;
  logic [1:0] prev_id;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic int dec(input logic [7:0] s);
    int v;
    v = 0;
    for (int i = 0; i < 4; i++)
      v += (int'(s[2*i+1]) + int'(s[2*i]) - 1) * (1 << i);
    return v;
  endfunction

  function automatic int lane_val(input int k);
    logic [7:0] a;
    logic [7:0] b;
    int va;
    int vb;
    a  = req_a[k*8 +: 8];
    b  = req_b[k*8 +: 8];
    va = req_subb_a[k] ? -dec(a) : dec(a);
    vb = req_subb_b[k] ? -dec(b) : dec(b);
    return va + vb;
  endfunction

  // Top digit zero keeps any signed sum inside 4 digits.
  function automatic logic [7:0] rand_op();
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[2*i +: 2] = 2'($urandom_range(0, 3));
    r[7:6] = 2'($urandom_range(1, 2));
    return r;
  endfunction

  always @(negedge clk) begin
    int base;
    int g;
    if (!srst_n) begin
      chk(req_ready == 4'b0, "rst_ready", int'(req_ready), 0);
      n_acc -= sb.size();
      sb.delete();
      rr_m = 0;
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk(rsp_valid, "hold_valid", int'(rsp_valid), 1);
        chk(rsp_s == prev_s, "hold_s", int'(rsp_s), int'(prev_s));
        chk(rsp_id == prev_id, "hold_id", int'(rsp_id), int'(prev_id));
      end
      if (rsp_valid && !rsp_ready)
        chk(req_ready == 4'b0, "bp_ready", int'(req_ready), 0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk(0, "sb_unexpected_rsp", int'(rsp_id), -1);
        end else begin
          e = sb.pop_front();
          chk(int'(rsp_id) == e.id, "rsp_id", int'(rsp_id), e.id);
          chk(dec(rsp_s) == e.val, "rsp_val", dec(rsp_s), e.val);
          n_rsp++;
        end
      end
      if (req_ready != 4'b0) begin
`ifdef RBR_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = rr_m;
`endif
        g = -1;
        for (int i = 0; i < 4; i++)
          if (g < 0 && req_valid[(base + i) % 4]) g = (base + i) % 4;
        if (g < 0) g = 0;
        chk(req_ready == 4'(1 << g), "grant", int'(req_ready), 1 << g);
        sb.push_back('{id: g, val: lane_val(g)});
        rr_m = (g + 1) % 4;
        n_acc++;
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_s    = rsp_s;
      prev_id   = rsp_id;
    end
  end

  task automatic reset_dut();
    @(posedge clk);
    #1;
    srst_n    = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    srst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || rsp_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(n < 60, "drain_timeout", n, 60);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    @(posedge clk);
    #1;
    req_a      = $urandom;
    req_b      = $urandom;
    req_subb_a = 4'($urandom);
    req_subb_b = 4'($urandom);
    req_a[v.id*8 +: 8] = v.a;
    req_b[v.id*8 +: 8] = v.b;
    req_subb_a[v.id]   = v.sa;
    req_subb_b[v.id]   = v.sb;
    req_valid = 4'(1 << v.id);
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[v.id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(req_ready[v.id], "vec_grant", int'(req_ready), 1 << v.id);
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk(lat == 2, "vec_latency", lat, 2);
    chk(int'(rsp_id) == v.id, "vec_id", int'(rsp_id), v.id);
    chk(dec(rsp_s) == v.exp, "vec_val", dec(rsp_s), v.exp);
    @(posedge clk);
  endtask

  initial begin
    vec_t       vt[7];
    int         n;
    int         exp_id;
    int         cyc;
    int         acc0;
    logic [3:0] acc;
    logic [3:0] exp_g;
    logic [7:0] s0;
    logic [1:0] id0;

    vt[0] = '{0, 8'b11_01_01_11, 8'b01_01_11_01, 0, 0, 11};
    vt[1] = '{2, 8'b11_01_01_11, 8'b01_01_11_01, 0, 1, 7};
    vt[2] = '{2, 8'b11_01_01_11, 8'b01_01_11_01, 1, 0, -7};
    vt[3] = '{1, 8'b00_01_01_00, 8'b01_00_10_11, 0, 0, -12};
    vt[4] = '{3, 8'b11_11_11_11, 8'b11_11_11_11, 0, 1, 0};
    vt[5] = '{0, 8'b10_10_01_01, 8'b00_11_00_11, 1, 1, 5};
    vt[6] = '{1, 8'b11_11_11_11, 8'b01_01_01_01, 1, 0, -15};

    srst_n     = 1'b0;
    req_valid  = 4'hF;
    req_a      = $urandom;
    req_b      = $urandom;
    req_subb_a = '0;
    req_subb_b = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(rsp_valid == 1'b0, "rst_valid", int'(rsp_valid), 0);
    chk(rsp_s == 8'h00, "rst_s", int'(rsp_s), 0);
    chk(rsp_id == 2'd0, "rst_id", int'(rsp_id), 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    srst_n    = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    reset_dut();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      n = 0;
      @(negedge clk);
      while (!(rsp_valid && rsp_ready) && n < 20) begin
        @(negedge clk);
        n++;
      end
`ifdef RBR_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = op % 4;
`endif
      chk(int'(rsp_id) == exp_id, "fair_id", int'(rsp_id), exp_id);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    reset_dut();
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(rsp_valid, "bp_first_valid", int'(rsp_valid), 1);
    s0  = rsp_s;
    id0 = rsp_id;
    repeat (10) @(negedge clk);
    chk(rsp_s == s0, "bp_stable_s", int'(rsp_s), int'(s0));
    chk(rsp_id == id0, "bp_stable_id", int'(rsp_id), int'(id0));
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
`ifdef RBR_ARB_FIXED_PRIO_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b0010;
`endif
    chk(rsp_valid, "bp_release_valid", int'(rsp_valid), 1);
    chk(req_ready == exp_g, "bp_next_grant", int'(req_ready), int'(exp_g));
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    reset_dut();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    n = 0;
    @(negedge clk);
    while (!req_ready[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(req_ready[2], "mid_grant", int'(req_ready), 4);
    @(posedge clk);
    #1;
    srst_n    = 1'b0;
    req_valid = 4'b1010;
    @(posedge clk);
    #1;
    srst_n = 1'b1;
    @(negedge clk);
    chk(rsp_valid == 1'b0, "mid_rst_valid", int'(rsp_valid), 0);
    chk(rsp_s == 8'h00, "mid_rst_s", int'(rsp_s), 0);
    chk(rsp_id == 2'd0, "mid_rst_id", int'(rsp_id), 0);
    chk(req_ready == 4'b0010, "mid_rst_grant", int'(req_ready), 2);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    reset_dut();
    acc0 = n_acc;
    cyc  = 0;
    while (n_acc - acc0 < NOPS && cyc < 60000) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) req_valid[k] = 1'b0;
        if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          req_valid[k]      = 1'b1;
          req_a[k*8 +: 8]   = rand_op();
          req_b[k*8 +: 8]   = rand_op();
          req_subb_a[k]     = 1'($urandom_range(0, 1));
          req_subb_b[k]     = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    chk(cyc < 60000, "rand_budget", cyc, 60000);
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    chk(sb.size() == 0, "sb_left", sb.size(), 0);
    chk(n_acc == n_rsp, "acc_vs_rsp", n_rsp, n_acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
